// File: rtl/pipeline_ex_muldiv_if.sv
// Handshake bundle between the EX stage and the multi-cycle M-extension unit.
// The master issues requests and drains results; the slave is the unit itself.
interface pipeline_ex_muldiv_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            funct3;
  logic                  is_word_op;
  logic [DATA_WIDTH-1:0] r1_val;
  logic [DATA_WIDTH-1:0] r2_val;
  logic [4:0]            dst_reg;
  logic                  kill;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] ex_res;
  logic [4:0]            out_dst_reg;
  logic                  busy;

  modport master (
    output in_valid, funct3, is_word_op, r1_val, r2_val, dst_reg, kill, out_ready,
    input  in_ready, out_valid, ex_res, out_dst_reg, busy
  );

  modport slave (
    input  in_valid, funct3, is_word_op, r1_val, r2_val, dst_reg, kill, out_ready,
    output in_ready, out_valid, ex_res, out_dst_reg, busy
  );
endinterface

// File: rtl/pipeline_ex_muldiv.sv
// Iterative RISC-V M-extension unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, followed by a sign-fixup cycle.
module pipeline_ex_muldiv #(
  parameter int DATA_WIDTH  = 64,
  parameter bit WORD_OPS_EN = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  pipeline_ex_muldiv_if.slave bus
);
  localparam int W       = DATA_WIDTH;
  localparam bit WORD_EN = WORD_OPS_EN && (DATA_WIDTH == 64);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t       state;
  logic [6:0]   cnt;
  logic [2:0]   op_f3;
  logic         op_word;
  logic         op_neg;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [4:0]   dst_q;
  logic         out_valid_q;
  logic [W-1:0] ex_res_q;
  logic [4:0]   out_dst_q;

  // Word results always sign-extend bit 31, even for the unsigned forms.
  function automatic logic [W-1:0] fin(input logic word, input logic [W-1:0] v);
    return word ? W'($signed(v[31:0])) : v;
  endfunction

  logic         req_word;
  logic         signed_a;
  logic         signed_b;
  logic         sign_a;
  logic         sign_b;
  logic         b_zero;
  logic         overflow;
  logic         special;
  logic         req_neg;
  logic [W-1:0] a_ext;
  logic [W-1:0] b_ext;
  logic [W-1:0] mag_a;
  logic [W-1:0] mag_b;
  logic [W-1:0] min_neg;
  logic [W-1:0] special_res;
  logic [6:0]   iter_last;

  always_comb begin
    req_word    = bus.is_word_op && WORD_EN;
    signed_a    = bus.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
    signed_b    = bus.funct3 inside {3'b001, 3'b100, 3'b110};
    a_ext       = bus.r1_val;
    b_ext       = bus.r2_val;
    if (req_word) begin
      a_ext = signed_a ? W'($signed(bus.r1_val[31:0])) : W'(bus.r1_val[31:0]);
      b_ext = signed_b ? W'($signed(bus.r2_val[31:0])) : W'(bus.r2_val[31:0]);
    end
    sign_a      = signed_a && a_ext[W-1];
    sign_b      = signed_b && b_ext[W-1];
    mag_a       = sign_a ? -a_ext : a_ext;
    mag_b       = sign_b ? -b_ext : b_ext;
    min_neg     = req_word ? W'($signed(32'h8000_0000)) : {1'b1, {(W-1){1'b0}}};
    b_zero      = (b_ext == '0);
    overflow    = bus.funct3[2] && !bus.funct3[0] && (a_ext == min_neg) && (b_ext == '1);
    req_neg     = (bus.funct3[2] && bus.funct3[1]) ? sign_a : (sign_a ^ sign_b);
    iter_last   = req_word ? 7'd31 : 7'(W - 1);
    special     = 1'b0;
    special_res = '0;
    if (req_word && (bus.funct3 inside {3'b001, 3'b010, 3'b011})) begin
      special = 1'b1;
    end else if (bus.funct3[2] && b_zero) begin
      special     = 1'b1;
      special_res = bus.funct3[1] ? fin(req_word, a_ext) : '1;
    end else if (overflow) begin
      special     = 1'b1;
      special_res = bus.funct3[1] ? '0 : a_ext;
    end
  end

  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic           div_take;
  logic [2*W-1:0] prod_full;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   mul_pick;
  logic [W-1:0]   div_pick;
  logic [W-1:0]   fix_res;

  // A word multiply only shifts 32 times, so its product sits 32 bits up in {hi, lo}.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, op_a} : '0);
    div_shift = {hi, lo[W-1]};
    div_take  = (div_shift >= {1'b0, op_b});
    prod_full = op_word ? ({hi, lo} >> 32) : {hi, lo};
    prod_fix  = op_neg ? -prod_full : prod_full;
    mul_pick  = (op_f3[1:0] == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
    div_pick  = op_f3[1] ? hi : lo;
    if (op_neg) begin
      div_pick = -div_pick;
    end
    fix_res   = op_f3[2] ? fin(op_word, div_pick) : fin(op_word, mul_pick);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      op_f3       <= '0;
      op_word     <= 1'b0;
      op_neg      <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      hi          <= '0;
      lo          <= '0;
      dst_q       <= '0;
      out_valid_q <= 1'b0;
      ex_res_q    <= '0;
      out_dst_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && !bus.kill) begin
            op_f3   <= bus.funct3;
            op_word <= req_word;
            op_neg  <= req_neg;
            op_a    <= mag_a;
            op_b    <= mag_b;
            dst_q   <= bus.dst_reg;
            cnt     <= iter_last;
            if (special) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              ex_res_q    <= special_res;
              out_dst_q   <= bus.dst_reg;
            end else begin
              state <= CALC;
              hi    <= '0;
              // The dividend is left-aligned so a 32-step word divide still consumes its MSB first.
              lo    <= bus.funct3[2] ? (req_word ? (mag_a << 32) : mag_a) : mag_b;
            end
          end
        end
        CALC: begin
          if (bus.kill) begin
            state <= IDLE;
          end else begin
            if (op_f3[2]) begin
              hi <= div_take ? W'(div_shift - {1'b0, op_b}) : div_shift[W-1:0];
              lo <= {lo[W-2:0], div_take};
            end else begin
              hi <= mul_sum[W:1];
              lo <= {mul_sum[0], lo[W-1:1]};
            end
            if (cnt == '0) begin
              state <= FIX;
            end else begin
              cnt <= cnt - 7'd1;
            end
          end
        end
        FIX: begin
          if (bus.kill) begin
            state <= IDLE;
          end else begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            ex_res_q    <= fix_res;
            out_dst_q   <= dst_q;
          end
        end
        DONE: begin
          if (bus.kill || bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.ex_res      = ex_res_q;
  assign bus.out_dst_reg = out_dst_q;
endmodule

// File: tb/tb_pipeline_ex_muldiv.sv
// Self-checking bench for pipeline_ex_muldiv (DATA_WIDTH=64): directed corner cases,
// randomized ops against an arithmetic reference model, backpressure, back-to-back and flush.
module tb_pipeline_ex_muldiv;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pipeline_ex_muldiv_if #(.DATA_WIDTH(64)) bus ();

  pipeline_ex_muldiv #(.DATA_WIDTH(64), .WORD_OPS_EN(1'b1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference result straight from the M-extension definitions.
  function automatic logic [63:0] ref_result(input logic [2:0] f3, input logic word,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [31:0]         a32;
    logic [31:0]         b32;
    logic [31:0]         r32;
    logic signed [127:0] sa;
    logic signed [127:0] sb;
    logic signed [127:0] sbu;
    logic signed [127:0] p;
    logic [127:0]        up;
    longint              sa64;
    longint              sb64;
    a32 = a[31:0];
    b32 = b[31:0];
    if (word) begin
      case (f3)
        3'd0: r32 = a32 * b32;
        3'd1, 3'd2, 3'd3: return 64'd0;
        3'd4: begin
          if (b32 == 0) r32 = '1;
          else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = a32;
          else r32 = $signed(a32) / $signed(b32);
        end
        3'd5: r32 = (b32 == 0) ? '1 : a32 / b32;
        3'd6: begin
          if (b32 == 0) r32 = a32;
          else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = 0;
          else r32 = $signed(a32) % $signed(b32);
        end
        default: r32 = (b32 == 0) ? a32 : a32 % b32;
      endcase
      return {{32{r32[31]}}, r32};
    end
    sa  = $signed(a);
    sb  = $signed(b);
    sbu = $signed({64'd0, b});
    up  = {64'd0, a} * {64'd0, b};
    sa64 = a;
    sb64 = b;
    case (f3)
      3'd0: return up[63:0];
      3'd1: begin p = sa * sb;  return p[127:64]; end
      3'd2: begin p = sa * sbu; return p[127:64]; end
      3'd3: return up[127:64];
      3'd4: begin
        if (b == 0) return '1;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
        return 64'(sa64 / sb64);
      end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return 64'd0;
        return 64'(sa64 % sb64);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycle in which out_valid first shows, counting the accept cycle as 0.
  function automatic int ref_cycle(input logic [2:0] f3, input logic word,
                                   input logic [63:0] a, input logic [63:0] b);
    logic special;
    logic zero;
    logic ovf;
    special = word && (f3 inside {3'd1, 3'd2, 3'd3});
    if (f3[2]) begin
      zero = word ? (b[31:0] == 0) : (b == 0);
      ovf  = !f3[0] && (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                             : (a == 64'h8000_0000_0000_0000 && b == '1));
      special = special || zero || ovf;
    end
    return special ? 1 : (word ? 34 : 66);
  endfunction

  task automatic drive_req(input logic [2:0] f3, input logic word, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] d);
    bus.in_valid   = 1'b1;
    bus.funct3     = f3;
    bus.is_word_op = word;
    bus.r1_val     = a;
    bus.r2_val     = b;
    bus.dst_reg    = d;
  endtask

  task automatic scramble_inputs();
    bus.in_valid   = 1'b0;
    bus.funct3     = 3'($urandom);
    bus.is_word_op = 1'($urandom);
    bus.r1_val     = {$urandom, $urandom};
    bus.r2_val     = {$urandom, $urandom};
    bus.dst_reg    = 5'($urandom);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic word, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] d,
                        output logic [63:0] res, output logic [4:0] rdst,
                        output int cyc, output logic ok);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    drive_req(f3, word, a, b, d);
    @(posedge clk); #1;
    scramble_inputs();
    cyc = 1;
    while (!bus.out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    ok   = bus.out_valid && (guard < 200);
    res  = bus.ex_res;
    rdst = bus.out_dst_reg;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic rand_op(output logic [2:0] f3, output logic w, output logic [63:0] a,
                         output logic [63:0] b, output logic [4:0] d);
    int kind;
    f3 = 3'($urandom_range(0, 7));
    w  = 1'($urandom_range(0, 1));
    a  = {$urandom, $urandom};
    b  = {$urandom, $urandom};
    d  = 5'($urandom);
    kind = $urandom_range(0, 9);
    case (kind)
      0: b = {$urandom, 32'd0};
      1: begin
        a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
        b = w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
      end
      2: b = 64'd1;
      3: begin
        a = {32'd0, $urandom};
        b = 64'($urandom_range(1, 100));
      end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.in_valid = 1'b1;
    bus.kill = 1'b0;
    bus.out_ready = 1'b0;
    bus.funct3 = 3'b100;
    bus.is_word_op = 1'b0;
    bus.r1_val = 64'd77;
    bus.r2_val = 64'd0;
    bus.dst_reg = 5'd9;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.busy, bus.ex_res, bus.out_dst_reg} !== {1'b0, 1'b0, 64'd0, 5'd0})
      begin
      errors++;
      $display("[TB] FAIL reset_state: got v=%b busy=%b res=%h dst=%0d, expected 0/0/0/0",
               bus.out_valid, bus.busy, bus.ex_res, bus.out_dst_reg);
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL reset_release: got ready=%b busy=%b valid=%b, expected 1/0/0",
               bus.in_ready, bus.busy, bus.out_valid);
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          cyc;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] f3, input logic word, input logic [63:0] a,
                              input logic [63:0] b, input logic [63:0] exp, input int cyc);
    vec_t v;
    v.f3 = f3; v.word = word; v.a = a; v.b = b; v.exp = exp; v.cyc = cyc;
    return v;
  endfunction

  task automatic test_directed();
    vec_t        vq[$];
    logic [63:0] res;
    logic [4:0]  rd;
    int          cyc;
    logic        ok;
    vq.push_back(mk(3'b100, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66));
    vq.push_back(mk(3'b110, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66));
    vq.push_back(mk(3'b101, 0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1));
    vq.push_back(mk(3'b110, 0, 64'h1234, 64'd0, 64'h1234, 1));
    vq.push_back(mk(3'b100, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1));
    vq.push_back(mk(3'b110, 0, 64'h8000_0000_0000_0000, '1, 64'd0, 1));
    vq.push_back(mk(3'b001, 0, '1, '1, 64'd0, 66));
    vq.push_back(mk(3'b011, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66));
    vq.push_back(mk(3'b010, 0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66));
    vq.push_back(mk(3'b000, 1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34));
    vq.push_back(mk(3'b100, 1, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1));
    vq.push_back(mk(3'b001, 1, 64'd5, 64'd7, 64'd0, 1));
    vq.push_back(mk(3'b101, 1, 64'hFFFF_FFF0, 64'd1, 64'hFFFF_FFFF_FFFF_FFF0, 34));
    foreach (vq[i]) begin
      run_op(vq[i].f3, vq[i].word, vq[i].a, vq[i].b, 5'(i + 1), res, rd, cyc, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL directed_%0d_timeout: no result, expected out_valid", i);
      end
      checks++;
      if (res !== vq[i].exp) begin
        errors++;
        $display("[TB] FAIL directed_%0d_result: got %h expected %h", i, res, vq[i].exp);
      end
      checks++;
      if (cyc != vq[i].cyc) begin
        errors++;
        $display("[TB] FAIL directed_%0d_latency: got cycle %0d expected %0d", i, cyc, vq[i].cyc);
      end
      checks++;
      if (rd !== 5'(i + 1)) begin
        errors++;
        $display("[TB] FAIL directed_%0d_dst: got %0d expected %0d", i, rd, i + 1);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  d;
    logic [63:0] res;
    logic [63:0] exp;
    logic [4:0]  rd;
    int          cyc;
    logic        ok;
    for (int n = 0; n < 150; n++) begin
      rand_op(f3, w, a, b, d);
      exp = ref_result(f3, w, a, b);
      run_op(f3, w, a, b, d, res, rd, cyc, ok);
      checks++;
      if (!ok || res !== exp || rd !== d || cyc != ref_cycle(f3, w, a, b)) begin
        errors++;
        $display("[TB] FAIL random_%0d f3=%0d w=%b a=%h b=%h: got res=%h dst=%0d cyc=%0d ok=%b, expected res=%h dst=%0d cyc=%0d",
                 n, f3, w, a, b, res, rd, cyc, ok, exp, d, ref_cycle(f3, w, a, b));
      end
      checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
        errors++;
        $display("[TB] FAIL random_%0d_handoff: got valid=%b ready=%b expected 0/1",
                 n, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp;
    int          cyc;
    exp = ref_result(3'b000, 1'b1, 64'h1234_5678_0001_0003, 64'hFFFF_FFFF_FFFF_FFFD);
    drive_req(3'b000, 1'b1, 64'h1234_5678_0001_0003, 64'hFFFF_FFFF_FFFF_FFFD, 5'd21);
    @(posedge clk); #1;
    scramble_inputs();
    cyc = 1;
    while (!bus.out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.ex_res, bus.out_dst_reg} !== {1'b1, 1'b0, exp, 5'd21})
        begin
        errors++;
        $display("[TB] FAIL hold_%0d: got v=%b rdy=%b res=%h dst=%0d expected v=1 rdy=0 res=%h dst=21",
                 i, bus.out_valid, bus.in_ready, bus.ex_res, bus.out_dst_reg, exp);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL hold_release: got valid=%b ready=%b expected 0/1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exq[$];
    logic [4:0]  dq[$];
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  d;
    logic        accepted;
    int          issued;
    int          got;
    int          cyc;
    issued = 0;
    got = 0;
    cyc = 0;
    rand_op(f3, w, a, b, d);
    drive_req(f3, w, a, b, d);
    bus.out_ready = 1'b1;
    while (got < 8 && cyc < 2000) begin
      if (bus.out_valid) begin
        checks++;
        if (exq.size() == 0) begin
          errors++;
          $display("[TB] FAIL b2b_extra: got unexpected result %h, expected none", bus.ex_res);
        end else if (bus.ex_res !== exq[0] || bus.out_dst_reg !== dq[0] || bus.in_ready !== 1'b0)
          begin
          errors++;
          $display("[TB] FAIL b2b_%0d: got res=%h dst=%0d rdy=%b expected res=%h dst=%0d rdy=0",
                   got, bus.ex_res, bus.out_dst_reg, bus.in_ready, exq[0], dq[0]);
        end
        if (exq.size() != 0) begin
          void'(exq.pop_front());
          void'(dq.pop_front());
        end
        got++;
      end
      accepted = bus.in_ready && bus.in_valid;
      if (accepted) begin
        exq.push_back(ref_result(f3, w, a, b));
        dq.push_back(d);
        issued++;
      end
      @(posedge clk); #1;
      cyc++;
      if (accepted) begin
        if (issued < 8) begin
          rand_op(f3, w, a, b, d);
          drive_req(f3, w, a, b, d);
        end else begin
          scramble_inputs();
        end
      end
    end
    bus.out_ready = 1'b0;
    checks++;
    if (got != 8) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d results expected 8", got);
    end
  endtask

  task automatic test_kill();
    logic [63:0] res;
    logic [63:0] exp;
    logic [4:0]  rd;
    int          cyc;
    logic        ok;
    logic        seen;
    bus.kill = 1'b1;
    drive_req(3'b100, 1'b0, 64'd100, 64'd7, 5'd3);
    @(posedge clk); #1;
    bus.kill = 1'b0;
    scramble_inputs();
    checks++;
    if ({bus.busy, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL kill_idle: got busy=%b ready=%b expected 0/1", bus.busy, bus.in_ready);
    end

    drive_req(3'b100, 1'b0, 64'hFFFF_0000_1234_5678, 64'd13, 5'd4);
    @(posedge clk); #1;
    scramble_inputs();
    repeat (9) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({bus.busy, bus.out_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL kill_calc_pre: got busy=%b valid=%b expected 1/0", bus.busy, bus.out_valid);
    end
    bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    checks++;
    if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL kill_calc: got valid=%b busy=%b ready=%b expected 0/0/1",
               bus.out_valid, bus.busy, bus.in_ready);
    end
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL kill_calc_silent: got out_valid=1 after kill expected 0");
    end
    exp = ref_result(3'b100, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9);
    run_op(3'b100, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd5, res, rd, cyc, ok);
    checks++;
    if (!ok || res !== exp || rd !== 5'd5) begin
      errors++;
      $display("[TB] FAIL kill_after_op: got res=%h dst=%0d ok=%b expected res=%h dst=5",
               res, rd, ok, exp);
    end

    drive_req(3'b011, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF, 5'd6);
    @(posedge clk); #1;
    scramble_inputs();
    repeat (64) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({bus.busy, bus.out_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL reset_fix_pre: got busy=%b valid=%b expected 1/0", bus.busy, bus.out_valid);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    checks++;
    if ({bus.out_valid, bus.busy, bus.in_ready, bus.ex_res, bus.out_dst_reg} !==
        {1'b0, 1'b0, 1'b1, 64'd0, 5'd0}) begin
      errors++;
      $display("[TB] FAIL reset_fix: got v=%b busy=%b rdy=%b res=%h dst=%0d expected 0/0/1/0/0",
               bus.out_valid, bus.busy, bus.in_ready, bus.ex_res, bus.out_dst_reg);
    end
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL reset_fix_silent: got out_valid=1 after reset expected 0");
    end
    exp = ref_result(3'b111, 1'b1, 64'h0000_0000_8000_0005, 64'd16);
    run_op(3'b111, 1'b1, 64'h0000_0000_8000_0005, 64'd16, 5'd7, res, rd, cyc, ok);
    checks++;
    if (!ok || res !== exp || rd !== 5'd7 || cyc != 34) begin
      errors++;
      $display("[TB] FAIL reset_after_op: got res=%h dst=%0d cyc=%0d ok=%b expected res=%h dst=7 cyc=34",
               res, rd, cyc, ok, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.kill = 1'b0;
    bus.out_ready = 1'b0;
    scramble_inputs();
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_kill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
